fix_to_float_pack: RTL and testbench

FIX_TO_FLOAT_PACK -- requirements
Module: fix_to_float_pack

---
 rtl/fix_to_float_pack.sv | 137 +++++++++++++
 tb/tb_fix_to_float_pack.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_to_float_pack.sv
// fix_to_float_pack
// Converts one signed fixed-point word (FRAC_BITS fractional bits) into an
// IEEE-754 single-precision encoding. Sequential normaliser: the magnitude is
// shifted left one bit per cycle until its MSB is set, counting shifts in k.
// The conversion is exact for WIDTH <= 24; wider words are truncated.
module fix_to_float_pack #(
    parameter int WIDTH     = 22,
    parameter int FRAC_BITS = 19
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [31:0]      result,
    output logic             done,
    output logic             busy
);

    // Shift counter must hold WIDTH-1, the largest possible shift count.
    localparam int KW       = $clog2(WIDTH);
    // Exponent when the captured MSB position needs no shifting.
    localparam int EXP_BIAS = 127 + (WIDTH - 1 - FRAC_BITS);
    // Width of the fraction bits concatenated with a 23-bit zero pad.
    localparam int MW       = WIDTH - 1 + 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ABS  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] data_q, data_d;
    logic                    sign_q, sign_d;
    logic        [WIDTH-1:0] mag_q, mag_d;
    logic        [KW-1:0]    k_q, k_d;
    logic        [31:0]      result_q, result_d;
    logic                    done_q, done_d;

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1),
    // which still fits because the result is treated as unsigned.
    function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] x);
        logic [WIDTH-1:0] ux;
        ux = x;
        return x[WIDTH-1] ? (~ux + {{(WIDTH-1){1'b0}}, 1'b1}) : ux;
    endfunction

    // Biased exponent: each left shift lowers the exponent by one.
    function automatic logic [7:0] exp_field(input logic [KW-1:0] k);
        return 8'(EXP_BIAS) - 8'(k);
    endfunction

    // Bits below the (implicit) leading one, left-aligned into 23 bits.
    function automatic logic [22:0] mant_field(input logic [WIDTH-2:0] frac);
        logic [MW-1:0] ext;
        ext = {frac, 23'd0};
        return ext[MW-1 -: 23];
    endfunction

    // Next-state and datapath decisions; every register holds by default.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        k_d      = k_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = data_in;
                    state_d = ABS;
                end
            end

            ABS: begin
                sign_d  = data_q[WIDTH-1];
                mag_d   = abs_mag(data_q);
                k_d     = '0;
                state_d = NORM;
            end

            NORM: begin
                if (mag_q == '0) begin
                    // Zero never reaches a set MSB; emit +0 directly.
                    result_d = 32'h0000_0000;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (mag_q[WIDTH-1]) begin
                    result_d = {sign_q, exp_field(k_q), mant_field(mag_q[WIDTH-2:0])};
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    mag_d = mag_q << 1;
                    k_d   = k_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            k_q      <= '0;
            result_q <= 32'h0000_0000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            k_q      <= k_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_fix_to_float_pack.sv
// Bench for fix_to_float_pack: directed conversions with literal results,
// plus randomized start/data/reset traffic compared against a cycle-level
// behavioural model every clock.
module tb_fix_to_float_pack;

    localparam int W  = 22;
    localparam int FB = 19;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          start   = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [31:0]   result;
    logic          done;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    fix_to_float_pack #(.WIDTH(W), .FRAC_BITS(FB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .data_in (data_in),
        .result  (result),
        .done    (done),
        .busy    (busy)
    );

    // ---------------- reference model ----------------
    function automatic int top_bit(input int mag);
        int p;
        p = 0;
        for (int i = 0; i < 31; i++) if (mag[i]) p = i;
        return p;
    endfunction

    function automatic logic [31:0] conv(input logic [W-1:0] d);
        int v, mag, p;
        logic [7:0]  e;
        logic [22:0] mt;
        v = int'($signed(d));
        if (v == 0) return 32'h0;
        mag = (v < 0) ? -v : v;
        p   = top_bit(mag);
        e   = 8'(127 + p - FB);
        mt  = 23'((mag << (23 - p)) & 32'h007F_FFFF);
        return {(v < 0), e, mt};
    endfunction

    function automatic int lat(input logic [W-1:0] d);
        int v, mag;
        v = int'($signed(d));
        if (v == 0) return 2;
        mag = (v < 0) ? -v : v;
        return 2 + (W - 1 - top_bit(mag));
    endfunction

    bit          m_busy   = 1'b0;
    bit          m_done   = 1'b0;
    int          m_cnt    = 0;
    logic [31:0] m_result = 32'h0;
    logic [31:0] m_pend   = 32'h0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_cnt    = 0;
            m_result = 32'h0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_done   = 1'b1;
                m_result = m_pend;
            end
            m_cnt--;
        end else if (start) begin
            m_busy = 1'b1;
            m_cnt  = lat(data_in);
            m_pend = conv(data_in);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (done !== m_done) begin
                failures++;
                $display("FAIL done t=%0t got=%b exp=%b", $time, done, m_done);
            end
            checks++;
            if (busy !== m_busy) begin
                failures++;
                $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, m_busy);
            end
            checks++;
            if (result !== m_result) begin
                failures++;
                $display("FAIL result t=%0t got=%h exp=%h", $time, result, m_result);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic run_conv(input string name, input logic [W-1:0] d,
                            input logic [31:0] exp_res, input int exp_lat);
        int  n;
        bit  seen;
        data_in = d;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 1'b0;
        n     = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                n    = i;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout got=no_done exp=done_within_40", name);
        end else begin
            check32({name, "_lat"}, 32'(n), 32'(exp_lat));
            check32({name, "_res"}, result, exp_res);
        end
        @(posedge clk); #1;
        check32({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [W-1:0] pick_data();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 22'h200000;
            2:       return W'(1) << $urandom_range(0, W - 1);
            3:       return -(W'(1) << $urandom_range(0, W - 2));
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int dn;

        // Model pins: hand-computed encodings and latencies.
        check32("pin_one",     conv(22'h080000), 32'h3F80_0000);
        check32("pin_mone",    conv(22'h380000), 32'hBF80_0000);
        check32("pin_1p5",     conv(22'h0C0000), 32'h3FC0_0000);
        check32("pin_m4",      conv(22'h200000), 32'hC080_0000);
        check32("pin_lsb",     conv(22'h000001), 32'h3600_0000);
        check32("pin_lat_lsb", 32'(lat(22'h000001)), 32'd23);
        check32("pin_lat_one", 32'(lat(22'h080000)), 32'd4);

        // Reset state, with start held high through reset.
        start = 1'b1;
        data_in = 22'h080000;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed conversions, back-to-back.
        run_conv("one",  22'h080000, 32'h3F80_0000, 4);
        run_conv("mone", 22'h380000, 32'hBF80_0000, 4);
        run_conv("1p5",  22'h0C0000, 32'h3FC0_0000, 4);
        run_conv("zero", 22'h000000, 32'h0000_0000, 2);
        run_conv("m4",   22'h200000, 32'hC080_0000, 2);
        run_conv("lsb",  22'h000001, 32'h3600_0000, 23);

        // Disturb start/data while busy: exactly one done, original data.
        data_in = 22'h0C0000;
        start   = 1'b1;
        @(posedge clk); #1;
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy) begin
                start   = $urandom_range(0, 1) == 1;
                data_in = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) dn++;
        end
        start = 1'b0;
        check32("busy_ignore_dones", 32'(dn), 32'd1);
        check32("busy_ignore_res", result, 32'h3FC0_0000);

        // Reset during NORM: aborted, no done afterwards.
        data_in = 22'h000001;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        check32("abort_busy", {31'd0, busy}, 32'd0);
        check32("abort_res", result, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check32("abort_no_done", 32'(dn), 32'd0);
        run_conv("after_abort", 22'h080000, 32'h3F80_0000, 4);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset_n = ($urandom_range(0, 299) != 0);
            start   = ($urandom_range(0, 3) == 0);
            data_in = pick_data();
        end
        reset_n = 1'b1;
        start   = 1'b0;
        repeat (30) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
